// File: rtl/io_master_if.sv
// io_master_if: groups the command, response and peripheral-bus signals of
// io_master into one bundle.
//   master modport : the io_master side (takes commands, drives the bus)
//   slave  modport : the command source / response sink / peripheral side
// Build option: IO_MASTER_MASK_EN adds cmd_mask, the per-command poll mask.
interface io_master_if #(
  parameter int WIDTH = 32
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_addr;
  logic [WIDTH-1:0] cmd_data;
`ifdef IO_MASTER_MASK_EN
  logic [WIDTH-1:0] cmd_mask;
`endif
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_err;
  logic [WIDTH-1:0] bus_addr;
  logic [WIDTH-1:0] bus_din;
  logic             bus_wen;
  logic             bus_cs;
  logic [WIDTH-1:0] bus_dout;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data,
`ifdef IO_MASTER_MASK_EN
    input  cmd_mask,
`endif
    output cmd_ready, rsp_valid, rsp_data, rsp_err,
    input  rsp_ready, bus_dout,
    output bus_addr, bus_din, bus_wen, bus_cs
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_data,
`ifdef IO_MASTER_MASK_EN
    output cmd_mask,
`endif
    input  cmd_ready, rsp_valid, rsp_data, rsp_err,
    output rsp_ready, bus_dout,
    input  bus_addr, bus_din, bus_wen, bus_cs
  );
endinterface

// File: rtl/io_master.sv
// io_master: bus initiator for the addr/din/wen/cs/dout peripheral bus.
// Accepts write / read / poll-until-zero / poll-until-nonzero commands and
// returns exactly one response per command. Polls re-read a register with
// POLL_GAP idle cycles between reads, optionally bounded by an attempt limit.
// Ports:
//   clk    - single clock, posedge
//   reset  - synchronous, active-low
//   io     - io_master_if.master: cmd_* (valid/ready command), rsp_* (valid/ready
//            response), bus_* (peripheral bus, bus_dout combinational from bus_addr)
// Build option: IO_MASTER_MASK_EN adds cmd_mask; poll conditions then test
// (bus_dout & mask) while rsp_data still returns the unmasked word.
module io_master #(
  parameter int WIDTH    = 32,
  parameter int POLL_GAP = 4
) (
  input logic         clk,
  input logic         reset,
  io_master_if.master io
);
  // state     | meaning
  // IDLE      | cmd_ready high, waiting for a command
  // XFER      | single bus_cs cycle; read data sampled at its end
  // POLL_WAIT | poll condition not met, POLL_GAP idle cycles before retry
  // RESP      | rsp_valid high until rsp_ready
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    XFER      = 2'd1,
    POLL_WAIT = 2'd2,
    RESP      = 2'd3
  } state_t;

  localparam logic [1:0] OP_WRITE = 2'b00;

  state_t           state_q, state_nxt;
  logic             ready_q;
  logic             err_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] din_q;
  logic [WIDTH-1:0] limit_q;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] rdata_q;
  logic [31:0]      gap_q;

  logic [WIDTH-1:0] cond_val;
  logic [WIDTH-1:0] cnt_inc;
  logic             accept;
  logic             met;
  logic             lim_hit;

`ifdef IO_MASTER_MASK_EN
  logic [WIDTH-1:0] mask_q;
  assign cond_val = io.bus_dout & mask_q;
`else
  assign cond_val = io.bus_dout;
`endif

  assign accept  = io.cmd_valid & ready_q;
  // attempt count saturates instead of wrapping back to a small value
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + WIDTH'(1);
  assign met     = op_q[0] ? (cond_val != '0) : (cond_val == '0);
  assign lim_hit = (limit_q != '0) && (cnt_inc == limit_q);

  // cmd_ready is registered so it stays low while reset is held
  assign io.cmd_ready = ready_q;
  assign io.rsp_valid = (state_q == RESP);
  assign io.rsp_data  = rdata_q;
  assign io.rsp_err   = err_q;
  assign io.bus_addr  = addr_q;
  assign io.bus_din   = din_q;
  assign io.bus_cs    = (state_q == XFER);
  assign io.bus_wen   = (state_q == XFER) && (op_q == OP_WRITE);

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_nxt = XFER;
      end
      XFER: begin
        if (!op_q[1] || met || lim_hit) state_nxt = RESP;
        else if (POLL_GAP == 0)         state_nxt = XFER;
        else                            state_nxt = POLL_WAIT;
      end
      POLL_WAIT: begin
        if (gap_q == '0) state_nxt = XFER;
      end
      RESP: begin
        if (io.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      op_q    <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      limit_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      gap_q   <= '0;
`ifdef IO_MASTER_MASK_EN
      mask_q  <= '0;
`endif
    end else begin
      state_q <= state_nxt;
      ready_q <= (state_nxt == IDLE);
      if (accept) begin
        op_q    <= io.cmd_op;
        addr_q  <= io.cmd_addr;
        // bus_din only carries data for writes; reads and polls drive zero
        din_q   <= (io.cmd_op == OP_WRITE) ? io.cmd_data : '0;
        limit_q <= io.cmd_data;
        cnt_q   <= '0;
`ifdef IO_MASTER_MASK_EN
        mask_q  <= io.cmd_mask;
`endif
      end
      if (state_q == XFER) begin
        cnt_q <= cnt_inc;
        // reload the gap timer on every transfer; POLL_WAIT counts it down
        gap_q <= 32'(POLL_GAP - 1);
        if (op_q == OP_WRITE) begin
          rdata_q <= '0;
          err_q   <= 1'b0;
        end else begin
          rdata_q <= io.bus_dout;
          err_q   <= op_q[1] & ~met & lim_hit;
        end
      end else if (state_q == POLL_WAIT) begin
        gap_q <= gap_q - 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_io_master.sv
module tb_io_master;
  localparam int W   = 32;
  localparam int GAP = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  io_master_if #(.WIDTH(W)) io ();

  io_master #(.WIDTH(W), .POLL_GAP(GAP)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io.master)
  );

  int checks   = 0;
  int failures = 0;

  // Peripheral model: plain registers, plus
  //   addr 8 : reads return the value, then decrement it (stops at 0)
  //   addr 9 : reads return 1 when reg 10 is 0, else 0; each read decrements reg 10
  //   addr 11: each read ORs 0x4 into the register
  logic [W-1:0] mem [16];
  logic [3:0]   sa;
  assign sa = io.bus_addr[3:0];
  assign io.bus_dout = (sa == 4'd9) ? ((mem[10] == '0) ? W'(1) : '0) : mem[sa];

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else if (io.bus_cs === 1'b1) begin
      if (io.bus_wen) mem[sa] <= io.bus_din;
      else begin
        case (sa)
          4'd8:  if (mem[8] != '0) mem[8] <= mem[8] - 1;
          4'd9:  if (mem[10] != '0) mem[10] <= mem[10] - 1;
          4'd11: mem[11] <= mem[11] | W'(4);
          default: ;
        endcase
      end
    end
  end

  // bus monitor: one entry per cs cycle
  int           cyc = 0;
  int           cs_cyc [$];
  logic         cs_wen [$];
  logic [W-1:0] cs_addr [$];
  logic [W-1:0] cs_din [$];
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (io.bus_cs === 1'b1) begin
      cs_cyc.push_back(cyc);
      cs_wen.push_back(io.bus_wen);
      cs_addr.push_back(io.bus_addr);
      cs_din.push_back(io.bus_din);
    end
  end

  logic [W-1:0] model_mem [8];

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic ack();
    io.rsp_ready = 1'b1;
    @(negedge clk);
    io.rsp_ready = 1'b0;
  endtask

  // called at a negedge; returns at the negedge of the cycle after acceptance
  task automatic send(input logic [1:0] op, input logic [W-1:0] addr, input logic [W-1:0] data);
    int n = 0;
    io.cmd_valid = 1'b1;
    io.cmd_op    = op;
    io.cmd_addr  = addr;
    io.cmd_data  = data;
    while (io.cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", W'(n < 50), W'(1));
    @(posedge clk);
    @(negedge clk);
    io.cmd_valid = 1'b0;
  endtask

  task automatic run(input string tag, input logic [1:0] op, input logic [W-1:0] addr,
                     input logic [W-1:0] data, input logic [W-1:0] exp_data,
                     input logic exp_err, input int exp_pulses, input int hold);
    int n;
    int bad;
    int base;
    base = cs_cyc.size();
    send(op, addr, data);
    n = 0;
    while (io.rsp_valid !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_rsp_wait"}, W'(n < 1000), W'(1));
    chk({tag, "_data"}, io.rsp_data, exp_data);
    chk({tag, "_err"}, W'(io.rsp_err), W'(exp_err));
    chk({tag, "_pulses"}, W'(cs_cyc.size() - base), W'(exp_pulses));
    bad = 0;
    for (int i = base; i < cs_cyc.size(); i++) begin
      if (cs_addr[i] !== addr) bad++;
      if (cs_wen[i] !== (op == 2'b00)) bad++;
      if (cs_din[i] !== ((op == 2'b00) ? data : '0)) bad++;
      if (i > base && cs_cyc[i] - cs_cyc[i-1] != GAP + 1) bad++;
    end
    chk({tag, "_bus"}, W'(bad), '0);
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      chk({tag, "_hold_flags"}, W'({io.rsp_valid, io.cmd_ready, io.bus_cs}), W'(3'b100));
      chk({tag, "_hold_data"}, io.rsp_data, exp_data);
    end
    chk({tag, "_hs_ready"}, W'(io.cmd_ready), '0);
    ack();
    chk({tag, "_after_hs"}, W'({io.rsp_valid, io.cmd_ready}), W'(2'b01));
  endtask

  initial begin
    int kind, a, v, lim, needed, reads;
    logic [W-1:0] d, expd;
    logic experr;

    reset        = 1'b0;
    io.cmd_valid = 1'b0;
    io.cmd_op    = '0;
    io.cmd_addr  = '0;
    io.cmd_data  = '0;
    io.rsp_ready = 1'b0;
`ifdef IO_MASTER_MASK_EN
    io.cmd_mask  = '1;
`endif
    for (int i = 0; i < 8; i++) model_mem[i] = '0;

    repeat (3) @(negedge clk);
    chk("rst_flags", W'({io.cmd_ready, io.rsp_valid, io.bus_cs, io.bus_wen}), '0);
    chk("rst_addr", io.bus_addr, '0);
    chk("rst_rsp_data", io.rsp_data, '0);
    reset = 1'b1;
    @(negedge clk);
    chk("rel_ready", W'(io.cmd_ready), W'(1));

    // write latency: cs in T+1, response from T+2
    send(2'b00, 1, 5);
    chk("wr_t1_cs_wen", W'({io.bus_cs, io.bus_wen, io.rsp_valid}), W'(3'b110));
    chk("wr_t1_addr", io.bus_addr, 1);
    chk("wr_t1_din", io.bus_din, 5);
    @(negedge clk);
    chk("wr_t2_flags", W'({io.rsp_valid, io.rsp_err, io.bus_cs}), W'(3'b100));
    chk("wr_t2_data", io.rsp_data, '0);
    ack();
    model_mem[1] = 5;

    run("wr3", 2'b00, 3, 'hABCD, '0, 1'b0, 1, 0);
    model_mem[3] = 'hABCD;
    run("rd3_bp", 2'b01, 3, '0, 'hABCD, 1'b0, 1, 5);

    run("wr8", 2'b00, 8, 3, '0, 1'b0, 1, 0);
    run("pz_count", 2'b10, 8, 0, '0, 1'b0, 4, 0);

    run("wr7", 2'b00, 7, 7, '0, 1'b0, 1, 0);
    model_mem[7] = 7;
    run("pz_limit", 2'b10, 7, 2, 7, 1'b1, 2, 1);

    run("wr10", 2'b00, 10, 2, '0, 1'b0, 1, 0);
    run("pnz", 2'b11, 9, 0, 1, 1'b0, 3, 0);

    // reset in the middle of a poll's wait phase
    run("wr8b", 2'b00, 8, 5, '0, 1'b0, 1, 0);
    send(2'b10, 8, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_flags", W'({io.bus_cs, io.rsp_valid, io.cmd_ready}), '0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) model_mem[i] = '0;
    @(negedge clk);
    chk("mid_rst_rel_ready", W'(io.cmd_ready), W'(1));
    run("wr5", 2'b00, 5, 'h55, '0, 1'b0, 1, 0);
    model_mem[5] = 'h55;
    run("rd5", 2'b01, 5, '0, 'h55, 1'b0, 1, 2);

`ifdef IO_MASTER_MASK_EN
    run("wr11", 2'b00, 11, 3, '0, 1'b0, 1, 0);
    io.cmd_mask = W'(4);
    run("mask_pnz", 2'b11, 11, 0, 7, 1'b0, 2, 0);
    io.cmd_mask = '1;
`endif

    for (int it = 0; it < 24; it++) begin
      kind = int'($urandom_range(0, 3));
      case (kind)
        0: begin
          a = int'($urandom_range(0, 7));
          d = $urandom;
          run("rnd_wr", 2'b00, W'(a), d, '0, 1'b0, 1, int'($urandom_range(0, 3)));
          model_mem[a] = d;
        end
        1: begin
          a = int'($urandom_range(0, 7));
          run("rnd_rd", 2'b01, W'(a), $urandom, model_mem[a], 1'b0, 1, int'($urandom_range(0, 3)));
        end
        default: begin
          v   = int'($urandom_range(0, 6));
          lim = int'($urandom_range(0, 8));
          needed = v + 1;
          if (lim != 0 && lim < needed) begin
            reads  = lim;
            experr = 1'b1;
            expd   = (kind == 2) ? W'(v - (lim - 1)) : '0;
          end else begin
            reads  = needed;
            experr = 1'b0;
            expd   = (kind == 2) ? '0 : W'(1);
          end
          if (kind == 2) begin
            run("rnd_wr8", 2'b00, 8, W'(v), '0, 1'b0, 1, 0);
            run("rnd_pz", 2'b10, 8, W'(lim), expd, experr, reads, int'($urandom_range(0, 3)));
          end else begin
            run("rnd_wr10", 2'b00, 10, W'(v), '0, 1'b0, 1, 0);
            run("rnd_pnz", 2'b11, 9, W'(lim), expd, experr, reads, int'($urandom_range(0, 3)));
          end
        end
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
